// File: rtl/wishbone_master_if.sv
// Wishbone classic bus bundle between one master and the shared interconnect.
// Member names are given from the master's point of view.
interface wishbone_master_if #(
    parameter int TAGSIZE = 2
);
    logic [31:0]        wb_dat_i;
    logic [TAGSIZE-1:0] wb_tgd_i;
    logic [31:0]        wb_dat_o;
    logic [TAGSIZE-1:0] wb_tgd_o;
    logic [31:0]        wb_adr_o;
    logic [TAGSIZE-1:0] wb_tga_o;
    logic               wb_ack_i;
    logic               wb_cyc_o;
    logic [TAGSIZE-1:0] wb_tgc_o;
    logic               wb_err_i;
    logic               wb_rty_i;
    logic [3:0]         wb_sel_o;
    logic               wb_stb_o;
    logic               wb_we_o;

    modport master (
        input  wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i, wb_rty_i,
        output wb_dat_o, wb_tgd_o, wb_adr_o, wb_tga_o, wb_cyc_o,
               wb_tgc_o, wb_sel_o, wb_stb_o, wb_we_o
    );

    modport slave (
        output wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  wb_dat_o, wb_tgd_o, wb_adr_o, wb_tga_o, wb_cyc_o,
               wb_tgc_o, wb_sel_o, wb_stb_o, wb_we_o
    );
endinterface

// File: rtl/wishbone_master.sv
// Single-transaction Wishbone master: one read or write per core request,
// with internal retry handling and a no-response watchdog.
module wishbone_master #(
    parameter int TAGSIZE   = 2,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        err_o,
    wishbone_master_if.master wb
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timeout_cnt_r;
    logic [RW-1:0]   retry_cnt_r;
    logic [RW-1:0]   retry_nxt_s;
    logic            unused_tgd_s;

    assign ready_o      = (state_r == IDLE);
    assign retry_nxt_s  = retry_cnt_r + RW'(1);
    assign unused_tgd_s = ^wb.wb_tgd_i;

    // Tags are not used by this master and are tied low.
    assign wb.wb_tgd_o = {TAGSIZE{1'b0}};
    assign wb.wb_tga_o = {TAGSIZE{1'b0}};
    assign wb.wb_tgc_o = {TAGSIZE{1'b0}};

    // Transaction FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            timeout_cnt_r <= {TW{1'b0}};
            retry_cnt_r   <= {RW{1'b0}};
            wb.wb_cyc_o   <= 1'b0;
            wb.wb_stb_o   <= 1'b0;
            wb.wb_we_o    <= 1'b0;
            wb.wb_adr_o   <= 32'h0000_0000;
            wb.wb_dat_o   <= 32'h0000_0000;
            wb.wb_sel_o   <= 4'h0;
            data_o        <= 32'h0000_0000;
            valid_o       <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        wb.wb_we_o    <= we_i;
                        wb.wb_adr_o   <= addr_i;
                        wb.wb_dat_o   <= data_i;
                        wb.wb_sel_o   <= sel_i;
                        timeout_cnt_r <= {TW{1'b0}};
                        retry_cnt_r   <= {RW{1'b0}};
                        wb.wb_cyc_o   <= 1'b1;
                        wb.wb_stb_o   <= 1'b1;
                        state_r       <= BUS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS: begin
                    // ACK wins over simultaneous ERR/RTY.
                    if (wb.wb_ack_i) begin
                        if (!wb.wb_we_o) begin
                            data_o <= wb.wb_dat_i;
                        end else begin
                            data_o <= data_o;
                        end
                        valid_o     <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        state_r     <= IDLE;
                    end else if (wb.wb_err_i) begin
                        valid_o     <= 1'b1;
                        err_o       <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        state_r     <= IDLE;
                    end else if (wb.wb_rty_i) begin
                        retry_cnt_r <= retry_nxt_s;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        if (retry_nxt_s == RW'(MAX_RETRY)) begin
                            valid_o <= 1'b1;
                            err_o   <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= BACKOFF;
                        end
                    end else if (timeout_cnt_r == TW'(TIMEOUT - 1)) begin
                        // Strobe has been up TIMEOUT cycles with no answer.
                        valid_o     <= 1'b1;
                        err_o       <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + TW'(1);
                        state_r       <= BUS;
                    end
                end
                BACKOFF: begin
                    timeout_cnt_r <= {TW{1'b0}};
                    wb.wb_cyc_o   <= 1'b1;
                    wb.wb_stb_o   <= 1'b1;
                    state_r       <= BUS;
                end
                default: begin
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Randomized scoreboard bench for wishbone_master: a scripted slave answers each
// strobe phase, and a transaction-level model predicts outcome, data and latency.
module tb_wishbone_master;

    localparam int TAGSIZE   = 2;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_RTY    = 2;
    localparam int K_ACKERR = 3;
    localparam int K_ACKRTY = 4;
    localparam int K_SILENT = 5;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        err_o;

    wishbone_master_if #(.TAGSIZE(TAGSIZE)) wb ();

    wishbone_master #(
        .TAGSIZE(TAGSIZE), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .data_o(data_o), .valid_o(valid_o), .err_o(err_o), .wb(wb)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    exp_t        sb[$];
    logic [31:0] model_data = 32'h0;

    // Slave script for the current request: one entry per strobe phase.
    int          p_kind[8];
    int          p_wait[8];
    logic [31:0] p_data[8];
    int          p_n = 0;
    int          ph = 0;
    int          pcnt = 0;

    bit          cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [3:0]  cur_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scripted slave: answers phase ph after p_wait[ph] strobe cycles.
    always @(negedge clk) begin
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_rty_i = 1'b0;
        wb.wb_dat_i = $urandom;
        wb.wb_tgd_i = 2'($urandom_range(0, 3));
        if (wb.wb_stb_o === 1'b1 && ph < p_n) begin
            if (pcnt == p_wait[ph]) begin
                case (p_kind[ph])
                    K_ACK:    wb.wb_ack_i = 1'b1;
                    K_ERR:    wb.wb_err_i = 1'b1;
                    K_RTY:    wb.wb_rty_i = 1'b1;
                    K_ACKERR: begin wb.wb_ack_i = 1'b1; wb.wb_err_i = 1'b1; end
                    K_ACKRTY: begin wb.wb_ack_i = 1'b1; wb.wb_rty_i = 1'b1; end
                    default:  wb.wb_ack_i = 1'b0;
                endcase
                wb.wb_dat_i = p_data[ph];
                ph++;
                pcnt = 0;
            end else begin
                pcnt++;
            end
        end else begin
            pcnt = 0;
        end
    end

    // Bus monitor: request fields stable and tags zero while strobing.
    always @(negedge clk) begin
        chk("cyc_eq_stb", {31'h0, wb.wb_cyc_o}, {31'h0, wb.wb_stb_o});
        if (wb.wb_stb_o === 1'b1) begin
            chk("bus_we",   {31'h0, wb.wb_we_o}, {31'h0, cur_we});
            chk("bus_adr",  wb.wb_adr_o, cur_addr);
            chk("bus_dat",  wb.wb_dat_o, cur_data);
            chk("bus_sel",  {28'h0, wb.wb_sel_o}, {28'h0, cur_sel});
            chk("bus_tags", {26'h0, wb.wb_tgd_o, wb.wb_tga_o, wb.wb_tgc_o}, 32'h0);
        end
    end

    // Completion monitor: pop the scoreboard on every valid_o pulse.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("err_o", {31'h0, err_o}, {31'h0, e.err});
                if (!e.err) chk("data_o", data_o, e.data);
                chk("latency", cyc_cnt - e.acc, e.lat);
            end
        end
    end

    // Transaction-level outcome: walk the phases, summing cycles per phase.
    function automatic exp_t model(input bit we);
        exp_t e;
        int   rc = 0;
        e.err  = 1'b1;
        e.data = model_data;
        e.lat  = 1;
        e.acc  = 0;
        for (int i = 0; i < p_n; i++) begin
            if (p_kind[i] == K_SILENT) begin
                e.lat += TIMEOUT;
                break;
            end
            e.lat += p_wait[i] + 1;
            if (p_kind[i] == K_ACK || p_kind[i] == K_ACKERR || p_kind[i] == K_ACKRTY) begin
                e.err = 1'b0;
                if (!we) e.data = p_data[i];
                break;
            end
            if (p_kind[i] == K_ERR) break;
            rc++;
            if (rc == MAX_RETRY) break;
            e.lat += 1;
        end
        return e;
    endfunction

    task automatic plan_add(input int kind, input int w, input logic [31:0] d);
        p_kind[p_n] = kind;
        p_wait[p_n] = w;
        p_data[p_n] = d;
        p_n++;
    endtask

    task automatic plan_clear();
        p_n  = 0;
        ph   = 0;
        pcnt = 0;
    endtask

    // Issue in the current cycle (called at a negedge); valid_i held one cycle.
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        exp_t e;
        e = model(we);
        e.acc = cyc_cnt;
        if (!e.err) model_data = e.data;
        sb.push_back(e);
        chk("ready_at_issue", {31'h0, ready_o}, 32'h1);
        cur_we = we; cur_addr = a; cur_data = d; cur_sel = s;
        valid_i = 1'b1; we_i = we; addr_i = a; data_i = d; sel_i = s;
        @(negedge clk);
        valid_i = 1'b0;
        we_i = 1'($urandom_range(0, 1)); addr_i = $urandom; data_i = $urandom;
        sel_i = 4'($urandom_range(0, 15));
    endtask

    // Returns at the negedge of the valid_o cycle, or flags a hang.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (valid_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk("completion_timeout", 32'h0, 32'h1);
            sb.delete();
        end
    endtask

    task automatic run(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        issue(we, a, d, s);
        wait_done();
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; we_i = 1'b0;
        addr_i = 32'h0; data_i = 32'h0; sel_i = 4'h0;
        cur_we = 1'b0; cur_addr = 32'h0; cur_data = 32'h0; cur_sel = 4'h0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_ready", {31'h0, ready_o}, 32'h1);
        chk("rst_cyc_stb_we", {29'h0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 32'h0);
        chk("rst_adr", wb.wb_adr_o, 32'h0);
        chk("rst_dat", wb.wb_dat_o, 32'h0);
        chk("rst_sel", {28'h0, wb.wb_sel_o}, 32'h0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_valid_err", {30'h0, valid_o, err_o}, 32'h0);
        @(negedge clk);

        plan_clear(); plan_add(K_ACK, 0, 32'hDEAD_BEEF);
        run(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        plan_clear(); plan_add(K_ACK, 3, 32'h5555_AAAA);
        run(1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3);
        plan_clear(); plan_add(K_RTY, 0, 32'h0); plan_add(K_RTY, 1, 32'h0);
        plan_add(K_ACK, 0, 32'hA5A5_0001);
        run(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        plan_clear(); plan_add(K_RTY, 0, 32'h0); plan_add(K_RTY, 0, 32'h0);
        plan_add(K_RTY, 2, 32'h0); plan_add(K_ACK, 0, 32'h1111_1111);
        run(1'b0, 32'h0000_0304, 32'h0, 4'hF);
        plan_clear(); plan_add(K_SILENT, 1000, 32'h0);
        run(1'b0, 32'h0000_0400, 32'h0, 4'h1);
        chk("cyc_after_timeout", {31'h0, wb.wb_cyc_o}, 32'h0);
        plan_clear(); plan_add(K_ERR, 2, 32'h0);
        run(1'b1, 32'h0000_0500, 32'hCAFE_0000, 4'hC);
        plan_clear(); plan_add(K_ACKERR, 0, 32'h0BAD_F00D);
        run(1'b0, 32'h0000_0504, 32'h0, 4'hF);
        plan_clear(); plan_add(K_ACK, TIMEOUT - 1, 32'h7777_0F0F);
        run(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        plan_clear(); plan_add(K_ACKRTY, 1, 32'h2468_ACE0);
        run(1'b0, 32'h0000_0604, 32'h0, 4'hF);

        for (int n = 0; n < 60; n++) begin
            int r;
            int fk;
            plan_clear();
            r = $urandom_range(0, 3);
            for (int i = 0; i < r; i++) plan_add(K_RTY, $urandom_range(0, 4), 32'h0);
            fk = $urandom_range(0, 9);
            if (fk < 5)       plan_add(K_ACK, $urandom_range(0, 4), $urandom);
            else if (fk == 5) plan_add(K_ERR, $urandom_range(0, 4), $urandom);
            else if (fk == 6) plan_add(K_ACKERR, $urandom_range(0, 4), $urandom);
            else if (fk == 7) plan_add(K_ACKRTY, $urandom_range(0, 4), $urandom);
            else if (fk == 8) plan_add(K_SILENT, 1000, 32'h0);
            else              plan_add(K_ACK, $urandom_range(5, TIMEOUT - 1), $urandom);
            run(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while strobing: request dropped, no completion pulse.
        plan_clear(); plan_add(K_SILENT, 1000, 32'h0);
        issue(1'b0, 32'h0000_0700, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        chk("stb_before_rst", {31'h0, wb.wb_stb_o}, 32'h1);
        rst_i = 1'b1;
        sb.delete();
        model_data = 32'h0;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_mid_cyc_stb", {30'h0, wb.wb_cyc_o, wb.wb_stb_o}, 32'h0);
        chk("rst_mid_ready", {31'h0, ready_o}, 32'h1);
        chk("rst_mid_valid", {31'h0, valid_o}, 32'h0);
        repeat (3) @(negedge clk);
        plan_clear(); plan_add(K_ACK, 1, 32'h600D_0001);
        run(1'b0, 32'h0000_0800, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
